// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot grant, a per-grant hold
// limit and a mandatory idle bubble between owners.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [7:0] rot;
  logic [1:0] offset;
  logic [1:0] winner;
  logic [1:0] owner;
  logic       rel_done, rel_drop, rel_limit;

  // Rotate the request vector so the pointer position lands on bit 0, then
  // pick the lowest set bit; winner is that offset added back onto the pointer.
  always_comb begin
    rot    = {req, req} >> ptr_q;
    offset = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) offset = 2'(i);
    end
    winner = ptr_q + offset;
  end

  // gnt_q is one-hot while in GRANT, so a plain OR encoder yields the owner.
  assign owner = {gnt_q[3] | gnt_q[2], gnt_q[3] | gnt_q[1]};

  assign rel_done  = done;
  assign rel_drop  = ~req[owner];
  assign rel_limit = (hold_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          gnt_d   = 4'b0001 << winner;
          busy_d  = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_limit) begin
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          ptr_d     = owner + 2'd1;
          timeout_d = rel_limit & ~rel_done & ~rel_drop;
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
